// File: rtl/counter_load_scheduler_pkg.sv
// Shared types and defaults for the round-robin counter load scheduler.
package counter_sched_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_load_scheduler_if.sv
// Request/grant bus between timer-style clients and the shared counter scheduler.
interface counter_load_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 4
);
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*CNT_W-1:0] start_val_i;
    logic [NUM_REQ*CNT_W-1:0] end_val_i;
    logic [NUM_REQ-1:0]       grant_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     busy_o;
    logic [CNT_W-1:0]         count_o;

    modport master (
        output req_i, start_val_i, end_val_i,
        input  grant_o, done_o, busy_o, count_o
    );

    modport slave (
        input  req_i, start_val_i, end_val_i,
        output grant_o, done_o, busy_o, count_o
    );
endinterface

// File: rtl/counter_load_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_c
);

    always_comb begin
        logic        found;
        int unsigned idx;
        o_gnt_c = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(i_ptr) + i) % NUM_REQ;
            if (!found && i_req[IDX_W'(idx)]) begin
                o_gnt_c[IDX_W'(idx)] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_load_scheduler.sv
// Shares one loadable up-counter among NUM_REQ requesters; the winner's count
// runs from its start value to its end value, then it gets a one-cycle done pulse.
module counter_load_scheduler
    import counter_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    counter_load_scheduler_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_end;
    logic [CNT_W-1:0]   r_count;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0]   w_win_idx;
    logic [CNT_W-1:0]   w_win_start;
    logic [CNT_W-1:0]   w_win_end;
    logic               w_owner_req;
    logic [IDX_W-1:0]   w_ptr_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (bus.req_i),
        .i_ptr   (r_ptr),
        .o_gnt_c (w_arb_gnt)
    );

    // Only the granted requester's values are ever selected for loading.
    always_comb begin
        w_win_idx   = '0;
        w_win_start = '0;
        w_win_end   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_win_idx   = IDX_W'(i);
                w_win_start = bus.start_val_i[i*CNT_W +: CNT_W];
                w_win_end   = bus.end_val_i[i*CNT_W +: CNT_W];
            end
        end
    end

    assign w_owner_req = bus.req_i[r_owner];
    assign w_ptr_next  = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    // Scheduler FSM, counter and pointer; an owner dropping its request aborts the run.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_end   <= '0;
            r_count <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req_i) begin
                        r_owner <= w_win_idx;
                        r_end   <= w_win_end;
                        r_count <= w_win_start;
                        r_grant <= w_arb_gnt;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= IDLE;
                    end else if (r_count == r_end) begin
                        r_done  <= r_grant;
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant_o = r_grant;
    assign bus.done_o  = r_done;
    assign bus.busy_o  = r_busy;
    assign bus.count_o = r_count;

endmodule

// File: tb/tb_counter_load_scheduler.sv
// Scoreboard bench: stimulus predicts each ownership episode, a monitor checks it cycle by cycle.
module tb_counter_load_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned CW = 4;

    typedef struct {
        logic [NR-1:0] gnt;
        logic [CW-1:0] s;
        logic [CW-1:0] e;
        int            n;
        bit            ab;
        int            j;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    counter_load_scheduler_if #(.NUM_REQ(NR), .CNT_W(CW)) bus();

    counter_load_scheduler #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   m_ptr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vals(input int r, input int s, input int e);
        bus.start_val_i[r*CW +: CW] = CW'(s);
        bus.end_val_i[r*CW +: CW]   = CW'(e);
    endtask

    // Monitor: pops one expected episode per new grant and follows it to its end.
    exp_t          cur;
    bit            active = 1'b0;
    int            idx    = 0;
    logic [CW-1:0] ec;

    always @(negedge clk) begin
        if (!reset_n) begin
            active = 1'b0;
        end else if (!active) begin
            if (bus.grant_o != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.grant_o), 32'd0);
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    idx    = 0;
                    chk("grant", 32'(bus.grant_o), 32'(cur.gnt));
                    chk("load_count", 32'(bus.count_o), 32'(cur.s));
                    chk("busy_on", 32'(bus.busy_o), 32'd1);
                    chk("done_early", 32'(bus.done_o), 32'd0);
                end
            end else begin
                chk("idle_done", 32'(bus.done_o), 32'd0);
            end
        end else begin
            idx++;
            if (cur.ab ? (idx <= cur.j) : (idx <= cur.n)) begin
                ec = CW'(int'(cur.s) + idx);
                chk("run_grant", 32'(bus.grant_o), 32'(cur.gnt));
                chk("run_count", 32'(bus.count_o), 32'(ec));
                chk("run_done", 32'(bus.done_o), 32'd0);
            end else if (cur.ab) begin
                ec = CW'(int'(cur.s) + cur.j);
                chk("abort_grant", 32'(bus.grant_o), 32'd0);
                chk("abort_done", 32'(bus.done_o), 32'd0);
                chk("abort_count", 32'(bus.count_o), 32'(ec));
                chk("abort_busy", 32'(bus.busy_o), 32'd0);
                active = 1'b0;
            end else if (idx == cur.n + 1) begin
                chk("done_pulse", 32'(bus.done_o), 32'(cur.gnt));
                chk("done_grant", 32'(bus.grant_o), 32'(cur.gnt));
                chk("done_count", 32'(bus.count_o), 32'(cur.e));
                chk("done_busy", 32'(bus.busy_o), 32'd1);
            end else begin
                chk("release_grant", 32'(bus.grant_o), 32'd0);
                chk("release_done", 32'(bus.done_o), 32'd0);
                chk("release_busy", 32'(bus.busy_o), 32'd0);
                active = 1'b0;
            end
        end
    end

    // One ownership episode: predict winner by rotating priority, then drive it to done or abort.
    task automatic do_txn(input logic [NR-1:0] mask, input bit want_ab, input int jreq);
        exp_t r;
        int   w;
        bit   got;
        w = -1;
        for (int i = 0; i < int'(NR); i++) begin
            int c;
            c = (m_ptr + i) % NR;
            if (w < 0 && mask[c]) w = c;
        end
        r.gnt = NR'(1) << w;
        r.s   = bus.start_val_i[w*CW +: CW];
        r.e   = bus.end_val_i[w*CW +: CW];
        r.n   = int'(CW'(r.e - r.s));
        r.ab  = want_ab && (r.n > 0);
        r.j   = 0;
        if (r.ab) r.j = (jreq < 0) ? int'($urandom_range(0, r.n - 1)) : jreq;
        sb.push_back(r);
        bus.req_i = mask;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            @(negedge clk);
            if (bus.grant_o != '0) got = 1'b1;
        end
        chk("grant_timeout", 32'(got), 32'd1);
        if (!got) begin
            bus.req_i = '0;
            sb.delete();
            repeat (3) @(negedge clk);
            return;
        end
        bus.req_i       = r.gnt;
        bus.start_val_i = (NR*CW)'($urandom);
        bus.end_val_i   = (NR*CW)'($urandom);
        if (r.ab) begin
            repeat (r.j) @(negedge clk);
            bus.req_i = '0;
        end else begin
            got = 1'b0;
            for (int t = 0; t < r.n + 6 && !got; t++) begin
                if (bus.done_o != '0) got = 1'b1;
                else @(negedge clk);
            end
            chk("done_timeout", 32'(got), 32'd1);
            bus.req_i = '0;
        end
        repeat (3) @(negedge clk);
        m_ptr = (w + 1) % NR;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  n_done;
        bool_dummy: begin end
        bus.req_i       = '1;
        bus.start_val_i = (NR*CW)'($urandom);
        bus.end_val_i   = (NR*CW)'($urandom);

        // Reset held with all requests asserted.
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        bus.req_i = '0;
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr   = 0;
        repeat (2) @(negedge clk);

        // All requesting, zero-length runs: strict rotation with an idle cycle between owners.
        for (int r = 0; r < int'(NR); r++) set_vals(r, 0, 0);
        for (int i = 0; i < 5; i++) begin
            exp_t x;
            x.gnt = NR'(1) << ((m_ptr + i) % NR);
            x.s = '0; x.e = '0; x.n = 0; x.ab = 1'b0; x.j = 0;
            sb.push_back(x);
        end
        bus.req_i = '1;
        n_done = 0;
        for (int t = 0; t < 60 && n_done < 5; t++) begin
            @(negedge clk);
            if (bus.done_o != '0) n_done++;
        end
        bus.req_i = '0;
        chk("rr_dones", 32'(n_done), 32'd5);
        m_ptr = (m_ptr + 5) % NR;
        repeat (3) @(negedge clk);

        // Plain run, wrap-around run, zero-length run.
        set_vals(1, 3, 6);
        do_txn(4'b0010, 1'b0, -1);
        set_vals(2, 14, 1);
        do_txn(4'b0100, 1'b0, -1);
        set_vals(0, 7, 7);
        do_txn(4'b0001, 1'b0, -1);

        // Abort at count 4, then another requester with its own start value.
        set_vals(3, 0, 9);
        do_txn(4'b1000, 1'b1, 4);
        set_vals(0, 5, 8);
        do_txn(4'b0001, 1'b0, -1);

        // Randomized contention, values and aborts.
        for (int k = 0; k < 40; k++) begin
            for (int r = 0; r < int'(NR); r++)
                set_vals(r, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            do_txn(NR'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0), -1);
        end

        // Reset in the middle of a 0 -> 10 run.
        begin
            exp_t x;
            bit   hit;
            set_vals(2, 0, 10);
            x.gnt = 4'b0100; x.s = 4'd0; x.e = 4'd10; x.n = 10; x.ab = 1'b0; x.j = 0;
            sb.push_back(x);
            bus.req_i = 4'b0100;
            hit = 1'b0;
            for (int t = 0; t < 16 && !hit; t++) begin
                @(negedge clk);
                if (bus.grant_o != '0 && bus.count_o == 4'd5) hit = 1'b1;
            end
            chk("reach_count5", 32'(hit), 32'd1);
            reset_n   = 1'b0;
            bus.req_i = '0;
            @(negedge clk);
            chk("mid_rst_count", 32'(bus.count_o), 32'd0);
            chk("mid_rst_grant", 32'(bus.grant_o), 32'd0);
            chk("mid_rst_done", 32'(bus.done_o), 32'd0);
            chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            sb.delete();
            m_ptr = 0;
            repeat (2) @(negedge clk);
        end

        // After reset requester 0 has priority again.
        for (int r = 0; r < int'(NR); r++) set_vals(r, r + 2, r + 4);
        do_txn(4'b1111, 1'b0, -1);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
